// File: rtl/aes_ecb_blk_packer.sv
// aes_ecb_blk_packer: packs 32-bit message words into zero-padded 128-bit AES blocks tagged with key/mode/last.
// Define AES_PACK_BYTE_SWAP_EN to byte-reverse each incoming word before packing.
module aes_ecb_blk_packer #(
    parameter int BITS_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [BITS_W-1:0] cfg_bits,
    input  logic [127:0]      cfg_key,
    input  logic              cfg_mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [127:0]      m_data,
    output logic [127:0]      m_key,
    output logic              m_mode,
    output logic              m_last,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;
    state_t              state_q, state_d;
    logic [127:0]        data_q, data_d, key_q, key_d;
    logic                mode_q, mode_d, last_q, last_d;
    logic [4:0]          tail_q, tail_d;
    logic [BITS_W-5:0]   rem_q, rem_d, words;
    logic [1:0]          widx_q, widx_d;
    logic [31:0]         word_sw, mask, word;

`ifdef AES_PACK_BYTE_SWAP_EN
    assign word_sw = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
`else
    assign word_sw = s_data;
`endif

    assign words = (BITS_W-4)'(cfg_bits >> 5) + (BITS_W-4)'(cfg_bits[4:0] != 5'd0);
    // only the final word of the job is trimmed to the message length
    assign mask  = (tail_q == 5'd0 || rem_q != (BITS_W-4)'(1)) ? '1 : ~(32'hffff_ffff >> tail_q);
    assign word  = word_sw & mask;

    assign cfg_ready = state_q == IDLE;
    assign s_ready   = state_q == COLLECT;
    assign m_valid   = state_q == EMIT;
    assign busy      = state_q != IDLE;
    assign m_data    = data_q;
    assign m_key     = key_q;
    assign m_mode    = mode_q;
    assign m_last    = last_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        mode_d  = mode_q;
        last_d  = last_q;
        tail_d  = tail_q;
        rem_d   = rem_q;
        widx_d  = widx_q;
        case (state_q)
            IDLE: if (cfg_valid) begin
                key_d   = cfg_key;
                mode_d  = cfg_mode;
                tail_d  = cfg_bits[4:0];
                rem_d   = words;
                widx_d  = 2'd0;
                data_d  = '0;
                last_d  = 1'b0;
                state_d = cfg_bits != '0 ? COLLECT : IDLE;
            end
            COLLECT: if (s_valid) begin
                data_d[{~widx_q, 5'b0} +: 32] = word;
                rem_d   = rem_q - 1'b1;
                widx_d  = widx_q + 1'b1;
                last_d  = rem_q == (BITS_W-4)'(1);
                state_d = (widx_q == 2'd3 || rem_q == (BITS_W-4)'(1)) ? EMIT : COLLECT;
            end
            EMIT: if (m_ready) begin
                data_d  = last_q ? data_q : '0;
                state_d = last_q ? IDLE : COLLECT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            last_q  <= 1'b0;
            tail_q  <= '0;
            rem_q   <= '0;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            tail_q  <= tail_d;
            rem_q   <= rem_d;
            widx_q  <= widx_d;
        end
    end
endmodule
